decode_execute_reg: RTL and testbench
=====================================

// Module: decode_execute_reg
// PURPOSE
//  ID/EX pipeline register sitting directly downstream of the register file.
//  Captures decode-stage operands, immediate, PC and control bundle each cycle
//  and presents them to the execute stage.
//  Supports stall (hold) and flush (bubble insertion), write-back bypass and
//  hard-wired x0, since the register file provides neither.
//  Keeps a saturating count of inserted bubbles for performance debug.
// PARAMETERS
//  CTRL_W    12   width of opaque decode control bundle (ALU op, mux selects, we, ...)
//  BCNT_W    16   width of bubble counter
// PORTS
//  clk          in   1        rising-edge clock, single clock domain
//  rst          in   1        asynchronous, active-low reset
//  stall_d      in   1        hold all E-stage registers this cycle
//  flush_e      in   1        load a bubble into E stage this cycle
//  valid_d      in   1        decode stage holds a real instruction
//  pc_d         in   32       PC of decode instruction
//  pc_plus4_d   in   32       PC+4 of decode instruction
//  rs1_d        in   5        source register 1 index (RF A1)
//  rs2_d        in   5        source register 2 index (RF A2)
//  rd_d         in   5        destination register index
//  rd1_d        in   32       RF read data 1 (RD1)
//  rd2_d        in   32       RF read data 2 (RD2)
//  imm_d        in   32       sign-extended immediate
//  ctrl_d       in   CTRL_W   decode control bundle
//  wb_we        in   1        write-back enable (same signal driving RF WE3)
//  wb_rd        in   5        write-back register (RF A3)
//  wb_data      in   32       write-back data (RF WD3)
//  valid_e      out  1        E stage holds a real instruction
//  pc_e, pc_plus4_e, imm_e  out  32   registered copies of *_d
//  rs1_e, rs2_e, rd_e       out  5    registered copies of *_d
//  op1_e, op2_e             out  32   registered, bypass-corrected operands
//  ctrl_e       out  CTRL_W   registered control bundle
//  bubble_cnt   out  BCNT_W   saturating count of flush cycles
// BEHAVIOUR
//  - Reset (rst=0, async): every output register = 0, incl. valid_e, ctrl_e,
//    bubble_cnt. Reset mid-operation discards E contents immediately.
//  - Per rising edge with rst=1, priority flush_e > stall_d > load:
//    flush_e=1: all E registers <= 0 (valid_e=0, ctrl_e=0, rd_e=0); ignores stall_d.
//    stall_d=1, flush_e=0: all E registers hold; no bypass re-evaluation.
//    otherwise: load every *_e from *_d; valid_e <= valid_d.
//  - Latency: exactly 1 cycle D->E; outputs driven only from registers.
//  - Operand select on load (op1 shown; op2 identical with rs2_d/rd2_d):
//    rs1_d==0                                  -> op1_e <= 0  (x0 hard-wired)
//    wb_we && wb_rd!=0 && wb_rd==rs1_d         -> op1_e <= wb_data (same-cycle bypass)
//    else                                      -> op1_e <= rd1_d
//    wb_rd==0 never bypasses; rs1_d==rs2_d==wb_rd bypasses both.
//  - ctrl_d passed through unmodified; block does not decode it.
//  - bubble_cnt: +1 on every edge with flush_e=1 (regardless of stall_d);
//    saturates at 2**BCNT_W-1; never wraps; cleared only by reset.
//  - No combinational path from any input to any output.
// TESTING
//  1 Reset: assert rst=0 mid-stream with valid_e=1 -> all outputs 0 asynchronously,
//    bubble_cnt=0.
//  2 Load: valid_d=1, pc_d=0x100, rs1_d=3, rd1_d=0xAAAA0001, imm_d=0xFFFFFFF0 ->
//    next edge valid_e=1, pc_e=0x100, op1_e=0xAAAA0001, imm_e=0xFFFFFFF0.
//  3 Bypass/x0: wb_we=1, wb_rd=5, wb_data=0x1234, rs1_d=5, rs2_d=5, rd1_d=rd2_d=0xDEAD
//    -> op1_e=op2_e=0x1234; repeat with rs1_d=0, wb_rd=0, rd1_d=0x77 -> op1_e=0.
//  4 Stall: load pc_d=0x200, then stall_d=1 for 3 cycles while pc_d changes ->
//    pc_e stays 0x200, op1_e unchanged even with matching write-back.
//  5 Flush vs stall: stall_d=1, flush_e=1 together -> valid_e=0, ctrl_e=0, rd_e=0,
//    bubble_cnt increments by 1.
//  6 Saturation (BCNT_W=4): 20 consecutive flush cycles -> bubble_cnt=15, stays 15.

Source files
------------

// File: rtl/decode_execute_if.sv
// ID/EX boundary bundle: decode-side operands, write-back snoop and the
// registered execute-stage view, with one modport per side.
interface decode_execute_if #(
    parameter int CTRL_W = 12,
    parameter int BCNT_W = 16
);
    logic              stall_d;
    logic              flush_e;
    logic              valid_d;
    logic [31:0]       pc_d;
    logic [31:0]       pc_plus4_d;
    logic [4:0]        rs1_d;
    logic [4:0]        rs2_d;
    logic [4:0]        rd_d;
    logic [31:0]       rd1_d;
    logic [31:0]       rd2_d;
    logic [31:0]       imm_d;
    logic [CTRL_W-1:0] ctrl_d;
    logic              wb_we;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;

    logic              valid_e;
    logic [31:0]       pc_e;
    logic [31:0]       pc_plus4_e;
    logic [31:0]       imm_e;
    logic [4:0]        rs1_e;
    logic [4:0]        rs2_e;
    logic [4:0]        rd_e;
    logic [31:0]       op1_e;
    logic [31:0]       op2_e;
    logic [CTRL_W-1:0] ctrl_e;
    logic [BCNT_W-1:0] bubble_cnt;

    modport master (
        output stall_d, flush_e, valid_d, pc_d, pc_plus4_d, rs1_d, rs2_d, rd_d,
               rd1_d, rd2_d, imm_d, ctrl_d, wb_we, wb_rd, wb_data,
        input  valid_e, pc_e, pc_plus4_e, imm_e, rs1_e, rs2_e, rd_e,
               op1_e, op2_e, ctrl_e, bubble_cnt
    );

    modport slave (
        input  stall_d, flush_e, valid_d, pc_d, pc_plus4_d, rs1_d, rs2_d, rd_d,
               rd1_d, rd2_d, imm_d, ctrl_d, wb_we, wb_rd, wb_data,
        output valid_e, pc_e, pc_plus4_e, imm_e, rs1_e, rs2_e, rd_e,
               op1_e, op2_e, ctrl_e, bubble_cnt
    );
endinterface

// File: rtl/decode_execute_reg.sv
// ID/EX pipeline register with stall/flush, write-back bypass, hard-wired x0
// and a saturating bubble counter. All outputs come straight from flops.
module decode_execute_reg #(
    parameter int CTRL_W = 12,
    parameter int BCNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    decode_execute_if.slave  bus
);

    logic              r_valid_e;
    logic [31:0]       r_pc_e;
    logic [31:0]       r_pc_plus4_e;
    logic [31:0]       r_imm_e;
    logic [4:0]        r_rs1_e;
    logic [4:0]        r_rs2_e;
    logic [4:0]        r_rd_e;
    logic [31:0]       r_op1_e;
    logic [31:0]       r_op2_e;
    logic [CTRL_W-1:0] r_ctrl_e;
    logic [BCNT_W-1:0] r_bubble_cnt;

    logic [31:0]       w_op1;
    logic [31:0]       w_op2;
    logic              w_bcnt_sat;

    // The RF is read and written in the same cycle without internal forwarding,
    // so a matching write-back must override the stale read data here.
    function automatic logic [31:0] sel_operand(
        input logic [4:0]  rs,
        input logic [31:0] rd_data,
        input logic        we,
        input logic [4:0]  wrd,
        input logic [31:0] wdata
    );
        logic [31:0] res;
        if (rs == 5'd0) begin
            res = 32'd0;
        end else if (we && (wrd != 5'd0) && (wrd == rs)) begin
            res = wdata;
        end else begin
            res = rd_data;
        end
        return res;
    endfunction

    // Bypass-corrected operands and counter saturation flag
    always_comb begin
        w_op1      = sel_operand(bus.rs1_d, bus.rd1_d, bus.wb_we, bus.wb_rd, bus.wb_data);
        w_op2      = sel_operand(bus.rs2_d, bus.rd2_d, bus.wb_we, bus.wb_rd, bus.wb_data);
        w_bcnt_sat = (r_bubble_cnt == {BCNT_W{1'b1}});
    end

    // E-stage registers: flush beats stall beats load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid_e    <= 1'b0;
            r_pc_e       <= 32'd0;
            r_pc_plus4_e <= 32'd0;
            r_imm_e      <= 32'd0;
            r_rs1_e      <= 5'd0;
            r_rs2_e      <= 5'd0;
            r_rd_e       <= 5'd0;
            r_op1_e      <= 32'd0;
            r_op2_e      <= 32'd0;
            r_ctrl_e     <= '0;
        end else if (bus.flush_e) begin
            r_valid_e    <= 1'b0;
            r_pc_e       <= 32'd0;
            r_pc_plus4_e <= 32'd0;
            r_imm_e      <= 32'd0;
            r_rs1_e      <= 5'd0;
            r_rs2_e      <= 5'd0;
            r_rd_e       <= 5'd0;
            r_op1_e      <= 32'd0;
            r_op2_e      <= 32'd0;
            r_ctrl_e     <= '0;
        end else if (!bus.stall_d) begin
            r_valid_e    <= bus.valid_d;
            r_pc_e       <= bus.pc_d;
            r_pc_plus4_e <= bus.pc_plus4_d;
            r_imm_e      <= bus.imm_d;
            r_rs1_e      <= bus.rs1_d;
            r_rs2_e      <= bus.rs2_d;
            r_rd_e       <= bus.rd_d;
            r_op1_e      <= w_op1;
            r_op2_e      <= w_op2;
            r_ctrl_e     <= bus.ctrl_d;
        end
    end

    // Bubble counter: counts every flush edge, sticks at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bubble_cnt <= '0;
        end else if (bus.flush_e && !w_bcnt_sat) begin
            r_bubble_cnt <= r_bubble_cnt + BCNT_W'(1);
        end
    end

    assign bus.valid_e    = r_valid_e;
    assign bus.pc_e       = r_pc_e;
    assign bus.pc_plus4_e = r_pc_plus4_e;
    assign bus.imm_e      = r_imm_e;
    assign bus.rs1_e      = r_rs1_e;
    assign bus.rs2_e      = r_rs2_e;
    assign bus.rd_e       = r_rd_e;
    assign bus.op1_e      = r_op1_e;
    assign bus.op2_e      = r_op2_e;
    assign bus.ctrl_e     = r_ctrl_e;
    assign bus.bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_decode_execute_reg.sv
// Table-driven bench for decode_execute_reg: each vector's expected E-stage
// state is queued when driven and compared one edge later.
module tb_decode_execute_reg;

    localparam int CTRL_W = 12;
    localparam int BCNT_W = 4;
    localparam logic [BCNT_W-1:0] BCNT_MAX = 4'd15;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [11:0] ctrl;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic [31:0] exp_op1;
        logic [31:0] exp_op2;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [11:0] ctrl;
        logic [3:0]  bcnt;
    } out_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    out_t model;
    out_t zero_out;
    out_t sb_q[$];
    vec_t vecs[12];

    decode_execute_if #(.CTRL_W(CTRL_W), .BCNT_W(BCNT_W)) u_if ();

    decode_execute_reg #(.CTRL_W(CTRL_W), .BCNT_W(BCNT_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic compare_out(input string tag, input out_t e);
        chk({tag, ".valid_e"},    {31'd0, u_if.valid_e}, {31'd0, e.valid});
        chk({tag, ".pc_e"},       u_if.pc_e, e.pc);
        chk({tag, ".pc_plus4_e"}, u_if.pc_plus4_e, e.pc4);
        chk({tag, ".imm_e"},      u_if.imm_e, e.imm);
        chk({tag, ".rs1_e"},      {27'd0, u_if.rs1_e}, {27'd0, e.rs1});
        chk({tag, ".rs2_e"},      {27'd0, u_if.rs2_e}, {27'd0, e.rs2});
        chk({tag, ".rd_e"},       {27'd0, u_if.rd_e}, {27'd0, e.rd});
        chk({tag, ".op1_e"},      u_if.op1_e, e.op1);
        chk({tag, ".op2_e"},      u_if.op2_e, e.op2);
        chk({tag, ".ctrl_e"},     {20'd0, u_if.ctrl_e}, {20'd0, e.ctrl});
        chk({tag, ".bubble_cnt"}, {28'd0, u_if.bubble_cnt}, {28'd0, e.bcnt});
    endtask

    // Drive one vector, push its expected E state, clock, pop and compare.
    task automatic apply(input string tag, input vec_t v);
        out_t e;
        u_if.stall_d    = v.stall;
        u_if.flush_e    = v.flush;
        u_if.valid_d    = v.valid;
        u_if.pc_d       = v.pc;
        u_if.pc_plus4_d = v.pc4;
        u_if.rs1_d      = v.rs1;
        u_if.rs2_d      = v.rs2;
        u_if.rd_d       = v.rd;
        u_if.rd1_d      = v.rd1;
        u_if.rd2_d      = v.rd2;
        u_if.imm_d      = v.imm;
        u_if.ctrl_d     = v.ctrl;
        u_if.wb_we      = v.wb_we;
        u_if.wb_rd      = v.wb_rd;
        u_if.wb_data    = v.wb_data;

        e = model;
        if (v.flush) begin
            e      = zero_out;
            e.bcnt = (model.bcnt == BCNT_MAX) ? BCNT_MAX : model.bcnt + 4'd1;
        end else if (!v.stall) begin
            e.valid = v.valid;
            e.pc    = v.pc;
            e.pc4   = v.pc4;
            e.imm   = v.imm;
            e.rs1   = v.rs1;
            e.rs2   = v.rs2;
            e.rd    = v.rd;
            e.op1   = v.exp_op1;
            e.op2   = v.exp_op2;
            e.ctrl  = v.ctrl;
        end
        model = e;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            compare_out(tag, sb_q.pop_front());
        end
    endtask

    function automatic vec_t mk(
        input logic stall, input logic flush, input logic valid,
        input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [4:0] rd, input logic [31:0] rd1, input logic [31:0] rd2,
        input logic [31:0] imm, input logic [11:0] ctrl, input logic wb_we,
        input logic [4:0] wb_rd, input logic [31:0] wb_data,
        input logic [31:0] exp_op1, input logic [31:0] exp_op2
    );
        vec_t v;
        v.stall = stall;  v.flush = flush;  v.valid = valid;
        v.pc = pc;        v.pc4 = pc + 32'd4;
        v.rs1 = rs1;      v.rs2 = rs2;      v.rd = rd;
        v.rd1 = rd1;      v.rd2 = rd2;      v.imm = imm;   v.ctrl = ctrl;
        v.wb_we = wb_we;  v.wb_rd = wb_rd;  v.wb_data = wb_data;
        v.exp_op1 = exp_op1;
        v.exp_op2 = exp_op2;
        return v;
    endfunction

    initial begin
        vec_t v;
        checks   = 0;
        errors   = 0;
        zero_out = '{1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 12'd0, 4'd0};
        model    = zero_out;

        // stall flush valid pc rs1 rs2 rd rd1 rd2 imm ctrl wb_we wb_rd wb_data | op1 op2
        vecs[0]  = mk(1'b0, 1'b0, 1'b1, 32'h100, 5'd3, 5'd4, 5'd7, 32'hAAAA0001, 32'h22,
                      32'hFFFFFFF0, 12'hABC, 1'b0, 5'd0, 32'd0, 32'hAAAA0001, 32'h22);
        vecs[1]  = mk(1'b0, 1'b0, 1'b1, 32'h104, 5'd5, 5'd5, 5'd6, 32'hDEAD, 32'hDEAD,
                      32'd8, 12'h123, 1'b1, 5'd5, 32'h1234, 32'h1234, 32'h1234);
        vecs[2]  = mk(1'b0, 1'b0, 1'b1, 32'h108, 5'd0, 5'd6, 5'd1, 32'h77, 32'h66,
                      32'd12, 12'h456, 1'b1, 5'd0, 32'h99, 32'd0, 32'h66);
        vecs[3]  = mk(1'b0, 1'b0, 1'b1, 32'h10C, 5'd8, 5'd9, 5'd2, 32'h11, 32'h12,
                      32'd16, 12'h789, 1'b0, 5'd8, 32'hBAD, 32'h11, 32'h12);
        vecs[4]  = mk(1'b0, 1'b0, 1'b1, 32'h110, 5'd1, 5'd2, 5'd3, 32'h31, 32'h32,
                      32'd20, 12'hFFF, 1'b1, 5'd2, 32'h5555, 32'h31, 32'h5555);
        vecs[5]  = mk(1'b0, 1'b0, 1'b0, 32'h114, 5'd4, 5'd0, 5'd4, 32'h41, 32'h42,
                      32'd24, 12'h001, 1'b0, 5'd0, 32'd0, 32'h41, 32'd0);
        vecs[6]  = mk(1'b0, 1'b0, 1'b1, 32'h200, 5'd10, 5'd11, 5'd12, 32'h300, 32'h301,
                      32'd28, 12'h0A5, 1'b0, 5'd0, 32'd0, 32'h300, 32'h301);
        vecs[7]  = mk(1'b1, 1'b0, 1'b1, 32'h204, 5'd10, 5'd11, 5'd13, 32'h400, 32'h401,
                      32'd32, 12'h5A0, 1'b1, 5'd10, 32'hCAFE, 32'hCAFE, 32'h401);
        vecs[8]  = mk(1'b1, 1'b0, 1'b1, 32'h208, 5'd10, 5'd11, 5'd14, 32'h500, 32'h501,
                      32'd36, 12'h5A1, 1'b1, 5'd11, 32'hBEEF, 32'h500, 32'hBEEF);
        vecs[9]  = mk(1'b1, 1'b0, 1'b0, 32'h20C, 5'd12, 5'd13, 5'd15, 32'h600, 32'h601,
                      32'd40, 12'h5A2, 1'b0, 5'd0, 32'd0, 32'h600, 32'h601);
        vecs[10] = mk(1'b1, 1'b1, 1'b1, 32'h210, 5'd14, 5'd15, 5'd16, 32'h700, 32'h701,
                      32'd44, 12'h5A3, 1'b0, 5'd0, 32'd0, 32'h700, 32'h701);
        vecs[11] = mk(1'b0, 1'b0, 1'b1, 32'h214, 5'd31, 5'd30, 5'd29, 32'h800, 32'h801,
                      32'd48, 12'h3C3, 1'b1, 5'd31, 32'hF00D, 32'hF00D, 32'h801);

        rst = 1'b0;
        v   = mk(1'b0, 1'b0, 1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 12'd0,
                 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
        u_if.stall_d = 1'b0; u_if.flush_e = 1'b0; u_if.valid_d = 1'b0;
        u_if.pc_d = 32'd0;   u_if.pc_plus4_d = 32'd0; u_if.rs1_d = 5'd0;
        u_if.rs2_d = 5'd0;   u_if.rd_d = 5'd0;   u_if.rd1_d = 32'd0;
        u_if.rd2_d = 32'd0;  u_if.imm_d = 32'd0; u_if.ctrl_d = 12'd0;
        u_if.wb_we = 1'b0;   u_if.wb_rd = 5'd0;  u_if.wb_data = 32'd0;
        @(posedge clk);
        #1;
        compare_out("reset", zero_out);
        #2;
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // Flush storm: counter climbs to 15 and sticks there.
        v = vecs[0];
        v.flush = 1'b1;
        for (int i = 0; i < 20; i++) begin
            v.stall = (i % 2 == 1) ? 1'b1 : 1'b0;
            apply($sformatf("sat%0d", i), v);
        end
        chk("sat.final", {28'd0, u_if.bubble_cnt}, 32'd15);

        // Mid-stream async reset with a live instruction in E.
        apply("pre_rst", vecs[6]);
        chk("pre_rst.valid", {31'd0, u_if.valid_e}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        model = zero_out;
        compare_out("async_rst", zero_out);
        #2;
        rst = 1'b1;
        apply("post_rst", vecs[0]);

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, 0 expected", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
